// File: rtl/eth_tx_packet_arbiter_if.sv
// Bundled handshake, data and status signals between the NIC TX streams, the MAC and the arbiter.
// No logic; carries wires only.
// The slave modport is the arbiter's view; master is the NIC/MAC side that drives it.
interface eth_tx_packet_arbiter_if #(
    parameter int NUM_NICS    = 3,
    parameter int DATA_WIDTH  = 256,
    parameter int EMPTY_WIDTH = 5
);
    localparam int GW = $clog2(NUM_NICS);

    logic [NUM_NICS*DATA_WIDTH-1:0]  in_data;
    logic [NUM_NICS-1:0]             in_valid;
    logic [NUM_NICS-1:0]             in_sop;
    logic [NUM_NICS-1:0]             in_eop;
    logic [NUM_NICS*EMPTY_WIDTH-1:0] in_empty;
    logic [NUM_NICS-1:0]             in_error;
    logic [NUM_NICS-1:0]             in_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_sop;
    logic                            out_eop;
    logic [EMPTY_WIDTH-1:0]          out_empty;
    logic                            out_error;
    logic                            out_ready;
    logic [GW-1:0]                   grant_id;
    logic [31:0]                     pkt_cnt;
    logic [15:0]                     trunc_cnt;
    logic [15:0]                     drop_cnt;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_error,
        output grant_id, pkt_cnt, trunc_cnt, drop_cnt
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_error,
        input  grant_id, pkt_cnt, trunc_cnt, drop_cnt
    );
endinterface

// File: rtl/eth_tx_packet_arbiter.sv
// Packet-atomic N:1 Avalon-ST TX arbiter (round-robin or fixed priority) with length watchdog.
// Latency: 1 cycle input beat to out_*; one idle arbitration cycle between packets.
// Backpressure: single output register, load = !out_valid || out_ready; granted in_ready follows load.
module eth_tx_packet_arbiter #(
    parameter int NUM_NICS      = 3,
    parameter int DATA_WIDTH    = 256,
    parameter int EMPTY_WIDTH   = 5,
    parameter int ARB_MODE      = 0,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic clk,
    input  logic reset,
    eth_tx_packet_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_NICS);
    localparam int BW = $clog2(MAX_PKT_BEATS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [GW-1:0]          r_grant;
    logic [BW-1:0]          r_beat_cnt;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_valid;
    logic                   r_out_sop;
    logic                   r_out_eop;
    logic [EMPTY_WIDTH-1:0] r_out_empty;
    logic                   r_out_error;
    logic [31:0]            r_pkt_cnt;
    logic [15:0]            r_trunc_cnt;
    logic [15:0]            r_drop_cnt;

    logic                   w_load;
    logic [NUM_NICS-1:0]    w_cand;
    logic [NUM_NICS-1:0]    w_orphan;
    logic [NUM_NICS-1:0]    w_in_ready;
    logic                   w_found;
    logic [GW-1:0]          w_winner;
    int                     w_idx;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [EMPTY_WIDTH-1:0] w_sel_empty;
    logic                   w_sel_valid;
    logic                   w_sel_sop;
    logic                   w_sel_eop;
    logic                   w_sel_error;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_trunc;
    logic                   w_drop;

    assign w_load      = !r_out_valid || bus.out_ready;
    assign w_cand      = bus.in_valid & bus.in_sop;
    assign w_orphan    = bus.in_valid & ~bus.in_sop;
    assign w_sel_data  = bus.in_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_empty = bus.in_empty[r_grant*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign w_sel_valid = bus.in_valid[r_grant];
    assign w_sel_sop   = bus.in_sop[r_grant];
    assign w_sel_eop   = bus.in_eop[r_grant];
    assign w_sel_error = bus.in_error[r_grant];
    assign w_accept    = (r_state == S_XFER) && w_load && w_sel_valid;
    assign w_last      = (r_beat_cnt == BW'(MAX_PKT_BEATS - 1));
    assign w_trunc     = w_accept && !w_sel_eop && w_last;
    assign w_drop      = ((r_state == S_DRAIN) && w_sel_valid) ||
                         ((r_state == S_IDLE) && (|w_orphan));

    // Pick the next packet owner among channels presenting SOP; the last loop hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_NICS - 1; i >= 0; i--) begin
                if (w_cand[i]) begin
                    w_found  = 1'b1;
                    w_winner = GW'(i);
                end
            end
        end else begin
            // Walk from farthest to nearest so the channel right after the last grant wins.
            for (int k = NUM_NICS; k >= 1; k--) begin
                w_idx = int'(r_grant) + k;
                if (w_idx >= NUM_NICS) w_idx = w_idx - NUM_NICS;
                if (w_cand[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = GW'(w_idx);
                end
            end
        end
    end

    // Ready: flush orphans while idle, follow the output register while transferring, sink while draining.
    always_comb begin
        w_in_ready = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_in_ready = w_orphan;
                S_XFER:  w_in_ready[r_grant] = w_load;
                S_DRAIN: w_in_ready[r_grant] = 1'b1;
                default: w_in_ready = '0;
            endcase
        end
    end

    // Packet state machine, grant holder and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= GW'(NUM_NICS - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_sel_eop)   r_state <= S_IDLE;
                        else if (w_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_sel_valid && w_sel_eop) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register; a truncated beat is rewritten as an errored EOP with no empty bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_empty <= '0;
            r_out_error <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data  <= w_sel_data;
                r_out_sop   <= w_sel_sop && (r_beat_cnt == '0);
                r_out_eop   <= w_sel_eop || w_last;
                r_out_empty <= w_trunc ? '0 : w_sel_empty;
                r_out_error <= w_sel_error || w_trunc;
            end
        end
    end

    // Statistics: packets wrap, truncations and drops saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_accept && (w_sel_eop || w_last))  r_pkt_cnt   <= r_pkt_cnt + 1'b1;
            if (w_trunc && (r_trunc_cnt != 16'hFFFF)) r_trunc_cnt <= r_trunc_cnt + 1'b1;
            if (w_drop && (r_drop_cnt != 16'hFFFF))   r_drop_cnt  <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_empty = r_out_empty;
    assign bus.out_error = r_out_error;
    assign bus.grant_id  = r_grant;
    assign bus.pkt_cnt   = r_pkt_cnt;
    assign bus.trunc_cnt = r_trunc_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_eth_tx_packet_arbiter.sv
// Bench for eth_tx_packet_arbiter: per-channel packet sources, per-channel expected-packet scoreboard.
// Expected output packets are derived from the packet-level rules (truncate to MAX beats, drop the rest).
// Second instance in fixed-priority mode checks that the low index starves the high one.
module tb_eth_tx_packet_arbiter;
    localparam int NUM  = 3;
    localparam int DW   = 32;
    localparam int EW   = 2;
    localparam int MAXB = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        error;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eth_tx_packet_arbiter_if #(.NUM_NICS(NUM), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) bus_a ();
    eth_tx_packet_arbiter_if #(.NUM_NICS(NUM), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) bus_b ();

    eth_tx_packet_arbiter #(.NUM_NICS(NUM), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW),
                            .ARB_MODE(0), .MAX_PKT_BEATS(MAXB))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

    eth_tx_packet_arbiter #(.NUM_NICS(NUM), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW),
                            .ARB_MODE(1), .MAX_PKT_BEATS(MAXB))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    beat_t src_mem [NUM][512];
    beat_t exp_mem [NUM][512];
    int    src_head [NUM];
    int    src_tail [NUM];
    int    exp_head [NUM];
    int    exp_tail [NUM];
    int    exp_pkt, exp_trunc, exp_drop;
    int    order_q [$];
    int    n_pass, n_checks;
    int    cyc, first_out_cyc, last_eop_cyc;
    int    mon_ch;
    bit    mon_busy;
    bit    gate_all, toggle, chk_idle;
    int    rdy_mode;
    logic [NUM-1:0] gate;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Queue a packet on a source and the form it must take at the output.
    task automatic push_pkt(input int ch, input int len);
        beat_t bt, e;
        for (int b = 0; b < len; b++) begin
            bt.data  = {4'(ch), 28'($urandom)};
            bt.sop   = (b == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            bt.eop   = (b == len - 1);
            bt.empty = 2'($urandom);
            bt.error = ($urandom_range(0, 5) == 0);
            src_mem[ch][src_tail[ch]] = bt;
            src_tail[ch]++;
            if (b < MAXB) begin
                e     = bt;
                e.sop = (b == 0);
                if (b == MAXB - 1 && len > MAXB) begin
                    e.eop   = 1'b1;
                    e.error = 1'b1;
                    e.empty = 2'd0;
                end
                exp_mem[ch][exp_tail[ch]] = e;
                exp_tail[ch]++;
            end
        end
        exp_pkt++;
        if (len > MAXB) begin
            exp_trunc++;
            exp_drop += len - MAXB;
        end
    endtask

    task automatic push_orphan(input int ch);
        beat_t bt;
        bt.data  = {4'(ch), 28'($urandom)};
        bt.sop   = 1'b0;
        bt.eop   = 1'b1;
        bt.empty = 2'd0;
        bt.error = 1'b0;
        src_mem[ch][src_tail[ch]] = bt;
        src_tail[ch]++;
        exp_drop++;
    endtask

    task automatic drive();
        beat_t bt;
        bit    have;
        for (int c = 0; c < NUM; c++) begin
            have = (src_head[c] < src_tail[c]);
            bt   = have ? src_mem[c][src_head[c]] : '0;
            bus_a.in_valid[c]          = have && gate[c];
            bus_a.in_data[c*DW +: DW]  = bt.data;
            bus_a.in_sop[c]            = bt.sop;
            bus_a.in_eop[c]            = bt.eop;
            bus_a.in_empty[c*EW +: EW] = bt.empty;
            bus_a.in_error[c]          = bt.error;
        end
    endtask

    task automatic monitor();
        beat_t got, e;
        int    ch;
        if (!bus_a.out_valid) return;
        got = {bus_a.out_data, bus_a.out_sop, bus_a.out_eop, bus_a.out_empty, bus_a.out_error};
        ch  = mon_busy ? mon_ch : int'(got.data[31:28]);
        check("out_channel_in_range", 64'(ch < NUM), 64'd1);
        if (ch >= NUM) return;
        e = (exp_head[ch] < exp_tail[ch]) ? exp_mem[ch][exp_head[ch]] : '0;
        check($sformatf("out_beat_ch%0d", ch), 64'(got), 64'(e));
        if (bus_a.out_ready) begin
            if (!mon_busy) begin
                order_q.push_back(ch);
                mon_ch = ch;
            end
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (exp_head[ch] < exp_tail[ch]) exp_head[ch]++;
            mon_busy = !got.eop;
            if (got.eop) last_eop_cyc = cyc;
        end
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, commit handshakes for the next rise.
    task automatic cycle();
        gate = gate_all ? '1 : NUM'($urandom);
        case (rdy_mode)
            0:       bus_a.out_ready = 1'b1;
            1:       bus_a.out_ready = toggle;
            default: bus_a.out_ready = ($urandom_range(0, 2) != 0);
        endcase
        toggle = ~toggle;
        drive();
        #1;
        if (chk_idle) begin
            check("idle_sop_in_ready", 64'(bus_a.in_ready), 64'd0);
            chk_idle = 1'b0;
        end
        monitor();
        for (int c = 0; c < NUM; c++)
            if (bus_a.in_valid[c] && bus_a.in_ready[c]) src_head[c]++;
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit all_done();
        bit d;
        d = !mon_busy && !bus_a.out_valid;
        for (int c = 0; c < NUM; c++)
            if (src_head[c] != src_tail[c] || exp_head[c] != exp_tail[c]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n;
        bit done;
        n    = 0;
        done = all_done();
        while (!done && n < budget) begin
            cycle();
            n++;
            done = all_done();
        end
        check(tag, 64'(done), 64'd1);
        cycle();
        cycle();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_cnt"},   64'(bus_a.pkt_cnt),   64'(exp_pkt));
        check({tag, "_trunc_cnt"}, 64'(bus_a.trunc_cnt), 64'(exp_trunc));
        check({tag, "_drop_cnt"},  64'(bus_a.drop_cnt),  64'(exp_drop));
    endtask

    initial begin
        int last_served, rr_start, c0, c2;
        int per_ch [NUM];

        n_pass = 0; n_checks = 0; cyc = 0;
        exp_pkt = 0; exp_trunc = 0; exp_drop = 0;
        mon_busy = 1'b0; mon_ch = 0; gate_all = 1'b1; toggle = 1'b1;
        chk_idle = 1'b0; rdy_mode = 0; gate = '1;
        first_out_cyc = -1; last_eop_cyc = -1;
        for (int c = 0; c < NUM; c++) begin
            src_head[c] = 0; src_tail[c] = 0; exp_head[c] = 0; exp_tail[c] = 0;
        end
        bus_a.in_data = '0; bus_a.in_valid = '0; bus_a.in_sop = '0; bus_a.in_eop = '0;
        bus_a.in_empty = '0; bus_a.in_error = '0; bus_a.out_ready = 1'b1;
        bus_b.in_data = '0; bus_b.in_valid = '0; bus_b.in_sop = '0; bus_b.in_eop = '0;
        bus_b.in_empty = '0; bus_b.in_error = '0; bus_b.out_ready = 1'b1;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_out_fields", 64'({bus_a.out_data, bus_a.out_sop, bus_a.out_eop,
                                     bus_a.out_empty, bus_a.out_error}), 64'd0);
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("rst_grant_id", 64'(bus_a.grant_id), 64'(NUM - 1));
        check_counters("rst");
        @(negedge clk);

        // Single 3-beat packet on channel 1: arbitration bubble then 3 back-to-back beats.
        push_pkt(1, 3);
        cyc = 0; chk_idle = 1'b1;
        wait_drain("single_drain", 50);
        check("single_first_out_cycle", 64'(first_out_cyc), 64'd2);
        check("single_last_out_cycle", 64'(last_eop_cyc), 64'd4);
        check("single_grant_id", 64'(bus_a.grant_id), 64'd1);
        check_counters("single");
        last_served = 1;

        // Round-robin fairness: every channel always has a 2-beat packet waiting.
        order_q.delete();
        for (int p = 0; p < 10; p++)
            for (int c = 0; c < NUM; c++) push_pkt(c, 2);
        wait_drain("rr_drain", 400);
        check("rr_packet_total", 64'(order_q.size()), 64'd30);
        rr_start = (last_served + 1) % NUM;
        for (int c = 0; c < NUM; c++) per_ch[c] = 0;
        foreach (order_q[i]) begin
            check($sformatf("rr_order_%0d", i), 64'(order_q[i]), 64'((rr_start + i) % NUM));
            if (order_q[i] >= 0 && order_q[i] < NUM) per_ch[order_q[i]]++;
        end
        for (int c = 0; c < NUM; c++)
            check($sformatf("rr_share_ch%0d", c), 64'(per_ch[c]), 64'd10);
        check_counters("rr");

        // Back-pressure: out_ready alternates during a 4-beat packet.
        rdy_mode = 1;
        push_pkt(0, 4);
        wait_drain("bp_drain", 100);
        check_counters("bp");
        rdy_mode = 0;

        // Watchdog: 6-beat packet truncated to 4, remaining 2 beats discarded.
        push_pkt(2, 6);
        wait_drain("wd_drain", 100);
        check_counters("wd");

        // Orphan beat while idle is flushed.
        push_orphan(0);
        wait_drain("orphan_drain", 50);
        check_counters("orphan");

        // Randomised traffic: lengths 1..6, random valid gaps and MAC back-pressure.
        gate_all = 1'b0; rdy_mode = 2;
        for (int p = 0; p < 40; p++) push_pkt($urandom_range(0, NUM - 1), $urandom_range(1, 6));
        wait_drain("rand_drain", 4000);
        check_counters("rand");
        gate_all = 1'b1; rdy_mode = 0;

        // Reset in the middle of a transfer.
        push_pkt(1, 6);
        repeat (3) cycle();
        check("pre_reset_out_valid", 64'(bus_a.out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus_a.in_ready), 64'd0);
        check("midrst_grant_id", 64'(bus_a.grant_id), 64'(NUM - 1));
        exp_pkt = 0; exp_trunc = 0; exp_drop = 0;
        check_counters("midrst");
        for (int c = 0; c < NUM; c++) begin
            src_head[c] = src_tail[c];
            exp_head[c] = exp_tail[c];
        end
        mon_busy = 1'b0;
        bus_a.in_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Fixed priority: single-beat packets held on channels 0 and 2.
        bus_b.in_data[0*DW +: DW] = 32'h0000_00A0;
        bus_b.in_data[2*DW +: DW] = 32'h2000_00A2;
        bus_b.in_sop = '1; bus_b.in_eop = '1;
        bus_b.in_valid = 3'b101;
        c0 = 0; c2 = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (bus_b.out_valid) begin
                if (bus_b.out_data[31:28] == 4'd0) c0++;
                if (bus_b.out_data[31:28] == 4'd2) c2++;
            end
            @(negedge clk);
        end
        check("fp_ch2_starved", 64'(c2), 64'd0);
        check("fp_ch0_served", 64'(c0 >= 10), 64'd1);
        bus_b.in_valid = 3'b100;
        c2 = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus_b.out_valid && bus_b.out_data[31:28] == 4'd2) c2++;
            @(negedge clk);
        end
        check("fp_ch2_served_after_ch0_idle", 64'(c2 >= 4), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/eth_tx_packet_arbiter.md
Name: eth_tx_packet_arbiter

Overview:
- Parametrised N-to-1 Avalon-ST packet arbiter that merges the TX streams of NUM_NICS NIC instances onto the single TX stream of the Ethernet MAC/PHY. Sits between the NICs' tx_* outputs and ethernet_mac tx_*_in, all in the MAC TX clock domain.
- Arbitration is packet-atomic: the grant is held from SOP to EOP.
- Supports round-robin or fixed-priority policy, a max-packet-length watchdog with truncation, orphan-beat flushing, and statistics counters.

Parameters:
- NUM_NICS, 3, number of input channels (2..16)
- DATA_WIDTH, 256, data bits per beat
- EMPTY_WIDTH, 5, width of the empty field; equals clog2(DATA_WIDTH/8)
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins)
- MAX_PKT_BEATS, 64, beats per packet before forced truncation (≥2)

Ports:
- clk  in  1  TX-domain clock (connected to eth_tx_clk)
- reset  in  1  asynchronous, active-high reset
- in_data  in  NUM_NICS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_NICS  per-channel valid
- in_sop  in  NUM_NICS  per-channel start of packet
- in_eop  in  NUM_NICS  per-channel end of packet
- in_empty  in  NUM_NICS*EMPTY_WIDTH  per-channel empty bytes on EOP beat
- in_error  in  NUM_NICS  per-channel error
- in_ready  out  NUM_NICS  per-channel ready (ready latency 0)
- out_data  out  DATA_WIDTH  merged stream data, to MAC
- out_valid  out  1  merged stream valid
- out_sop  out  1  merged stream start of packet
- out_eop  out  1  merged stream end of packet
- out_empty  out  EMPTY_WIDTH  merged stream empty
- out_error  out  1  merged stream error
- out_ready  in  1  MAC tx_ready
- grant_id  out  clog2(NUM_NICS)  currently or last granted channel
- pkt_cnt  out  32  packets forwarded (EOP beats loaded into output register); wraps
- trunc_cnt  out  16  packets truncated by the watchdog; saturating
- drop_cnt  out  16  input beats discarded; saturating

Behaviour:
- Reset (asynchronous):
  - out_valid=0 and all out_* = 0; in_ready=0.
  - State=IDLE.
  - grant_id=NUM_NICS-1, so channel 0 has first priority.
  - All counters and beat_cnt = 0.
- Output register: single stage. load = !out_valid || out_ready.
  - Accepted input beat appears on out_* the next cycle (latency 1).
  - out_valid falls when out_ready=1 and no new load.
  - Full throughput during XFER.
- States IDLE, XFER, DRAIN.
- IDLE:
  - Candidates are channels with in_valid && in_sop.
  - ARB_MODE=0: search starts at (grant_id+1) mod NUM_NICS, wrapping.
  - ARB_MODE=1: lowest index wins.
  - On a winner: grant_id←winner, beat_cnt←0, go to XFER next cycle. No beat is accepted from the winner in this cycle (one-cycle arbitration bubble).
  - Orphan flush: any channel with in_valid && !in_sop gets in_ready=1 in IDLE; its beat is discarded and drop_cnt increments by 1 per cycle (multiple simultaneous orphans count once per cycle).
  - SOP channels see in_ready=0.
- XFER:
  - in_ready[grant_id] = load; all other in_ready = 0.
  - Accepted beat fields are copied to the output register unchanged; beat_cnt increments.
  - Accepted beat with eop=1: pkt_cnt++, go to IDLE.
  - Accepted beat with eop=0 and beat_cnt==MAX_PKT_BEATS-1: forward it with out_eop=1, out_error=1, out_empty=0. Then pkt_cnt++, trunc_cnt++, go to DRAIN.
  - A mid-packet sop=1 beat is forwarded as data (sop bit cleared); this is not a new packet.
- DRAIN:
  - in_ready[grant_id]=1; beats are discarded and drop_cnt increments per beat.
  - The discarded EOP beat returns the FSM to IDLE.
- Simultaneous events:
  - The EOP accept and the next arbitration never share a cycle; IDLE always follows for at least 1 cycle.
  - A single-beat packet (sop && eop) costs 2 cycles at full rate.
- Back-pressure: out_ready=0 with out_valid=1 holds out_* stable and drives in_ready=0 for the granted channel.
- Counters: pkt_cnt wraps at 2^32; trunc_cnt and drop_cnt saturate at 16'hFFFF.
- Reset mid-packet aborts the transfer; the MAC may see a packet without EOP. That is acceptable because the MAC resets together with the arbiter.

Test Plan:
- Single packet: ch1 sends 3 beats (D0 sop … D2 eop), out_ready=1 → out_valid in cycles 2-4, out_sop on D0, out_eop on D2, grant_id=1, pkt_cnt=1.
- RR fairness: NUM_NICS=3, all channels continuously send 2-beat packets, 30 packets total → output channel order 0,1,2,0,1,2…; each channel gets 10 packets; no interleaving within a packet.
- Fixed priority: ARB_MODE=1, ch0 and ch2 both continuously valid → only ch0 packets emitted; ch2 is served once ch0 goes idle.
- Back-pressure: toggle out_ready 1/0 each cycle during a 4-beat packet → out_* stable while stalled, all 4 beats delivered in order, no duplicates.
- Watchdog: MAX_PKT_BEATS=4, ch2 sends 6 beats → 4 beats out, the 4th with eop=1, error=1, empty=0; 2 beats dropped; trunc_cnt=1, drop_cnt=2, then IDLE.
- Orphan and reset: ch0 presents valid with sop=0 in IDLE → accepted, drop_cnt=1. Assert reset mid-XFER → out_valid and in_ready drop to 0 immediately, all counters 0, grant_id=NUM_NICS-1.
